// File: rtl/player_motion.sv
// Platformer avatar motion: horizontal walking with edge saturation, and a
// grounded/rising/falling vertical model advanced once per physics tick.
module player_motion #(
  parameter logic [9:0] START_X  = 10'd20,
  parameter logic [8:0] START_Y  = 9'd400,
  parameter logic [9:0] X_MIN    = 10'd6,
  parameter logic [9:0] X_MAX    = 10'd637,
  parameter logic [8:0] Y_MAX    = 9'd479,
  parameter logic [4:0] JUMP_VEL = 5'd6,
  parameter logic [4:0] MAX_FALL = 5'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       left_press,
  input  logic       right_press,
  input  logic       jump_press,
  input  logic       on_platform,
  output logic [9:0] x,
  output logic [8:0] y,
  output logic [9:0] furthest_x,
  output logic       airborne,
  output logic       fell
);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

  state_t     state, state_nx;
  logic [4:0] vy, vy_nx;
  logic [8:0] y_nx;
  logic [9:0] x_nx;
  logic       fell_nx;
  logic       jump_prev, jump_req, jump_rise;
  logic [9:0] y_wide, y_sum;
  logic [5:0] vy_inc;

  assign jump_rise = jump_press & ~jump_prev;

  // An edge seen on a tick cycle arms the request for the following tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      jump_prev <= 1'b0;
      jump_req  <= 1'b0;
    end else begin
      jump_prev <= jump_press;
      if (tick)
        jump_req <= jump_rise;
      else if (jump_rise)
        jump_req <= 1'b1;
    end
  end

  always_comb begin
    x_nx = x;
    if (left_press && !right_press)
      x_nx = (x <= X_MIN) ? X_MIN : x - 10'd1;
    else if (right_press && !left_press)
      x_nx = (x >= X_MAX) ? X_MAX : x + 10'd1;
  end

  assign y_wide = {1'b0, y};
  assign y_sum  = y_wide + {5'b0, vy};
  assign vy_inc = {1'b0, vy} + 6'd1;

  always_comb begin
    state_nx = state;
    vy_nx    = vy;
    y_nx     = y;
    fell_nx  = 1'b0;
    case (state)
      GROUNDED: begin
        if (jump_req) begin
          state_nx = RISING;
          vy_nx    = JUMP_VEL;
        end else if (!on_platform) begin
          state_nx = FALLING;
          vy_nx    = 5'd1;
        end
      end
      RISING: begin
        if ({5'b0, vy} > y_wide) begin
          y_nx     = '0;
          vy_nx    = '0;
          state_nx = FALLING;
        end else begin
          y_nx  = y - {4'b0, vy};
          vy_nx = (vy == 5'd0) ? 5'd0 : vy - 5'd1;
          if (vy_nx == 5'd0)
            state_nx = FALLING;
        end
      end
      FALLING: begin
        if (on_platform) begin
          state_nx = GROUNDED;
          vy_nx    = '0;
        end else if (y_sum >= {1'b0, Y_MAX}) begin
          y_nx     = Y_MAX;
          vy_nx    = '0;
          state_nx = GROUNDED;
          fell_nx  = 1'b1;
        end else begin
          y_nx  = y_sum[8:0];
          vy_nx = (vy_inc >= {1'b0, MAX_FALL}) ? MAX_FALL : vy_inc[4:0];
        end
      end
      default: begin
        state_nx = FALLING;
        vy_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FALLING;
      vy         <= '0;
      x          <= START_X;
      y          <= START_Y;
      furthest_x <= START_X;
      airborne   <= 1'b1;
      fell       <= 1'b0;
    end else if (tick) begin
      state    <= state_nx;
      vy       <= vy_nx;
      x        <= x_nx;
      y        <= y_nx;
      airborne <= (state_nx != GROUNDED);
      fell     <= fell_nx;
      if (x_nx > furthest_x)
        furthest_x <= x_nx;
    end else begin
      fell <= 1'b0;
    end
  end

endmodule

// File: tb/tb_player_motion.sv
// Scoreboarded bench for player_motion: a driver advances a plain-arithmetic
// physics model per clock and queues expected outputs; a monitor compares them.
module tb_player_motion;

  localparam int SX = 20, SY = 400, XMIN = 6, XMAX = 637, YMAX = 479, JV = 6, MF = 4;
  localparam int M_GND = 0, M_UP = 1, M_DN = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0, left_press = 1'b0, right_press = 1'b0;
  logic       jump_press = 1'b0, on_platform = 1'b0;
  logic [9:0] x, furthest_x;
  logic [8:0] y;
  logic       airborne, fell;

  player_motion #(
    .START_X(10'd20), .START_Y(9'd400), .X_MIN(10'd6), .X_MAX(10'd637),
    .Y_MAX(9'd479), .JUMP_VEL(5'd6), .MAX_FALL(5'd4)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .left_press(left_press),
    .right_press(right_press), .jump_press(jump_press), .on_platform(on_platform),
    .x(x), .y(y), .furthest_x(furthest_x), .airborne(airborne), .fell(fell)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int fx; int air; int fell; } exp_t;
  exp_t sb[$];

  int n_cmp = 0, n_bad = 0;
  int m_x, m_y, m_fx, m_mode, m_vy, m_req, m_prev, m_air, m_fell;
  logic want_rst = 1'b0;
  int s_x, s_y, s_fx, s_air, s_fell;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = SX; m_y = SY; m_fx = SX; m_mode = M_DN; m_vy = 0;
    m_req = 0; m_prev = 0; m_air = 1; m_fell = 0;
  endtask

  task automatic push_model();
    exp_t e;
    e.x = m_x; e.y = m_y; e.fx = m_fx; e.air = m_air; e.fell = m_fell;
    sb.push_back(e);
  endtask

  // Effect of the coming rising edge given the inputs now applied.
  task automatic model_edge();
    int rise, use_req, dx;
    if (!reset) begin
      model_reset();
    end else begin
      rise = (jump_press && !m_prev) ? 1 : 0;
      m_prev = jump_press ? 1 : 0;
      use_req = m_req;
      m_fell = 0;
      if (tick) begin
        m_req = rise;
        dx = (left_press && !right_press) ? -1 : (right_press && !left_press) ? 1 : 0;
        m_x = m_x + dx;
        if (m_x < XMIN) m_x = XMIN;
        if (m_x > XMAX) m_x = XMAX;
        if (m_x > m_fx) m_fx = m_x;
        case (m_mode)
          M_GND: begin
            if (use_req != 0) begin m_mode = M_UP; m_vy = JV; end
            else if (!on_platform) begin m_mode = M_DN; m_vy = 1; end
          end
          M_UP: begin
            if (m_y - m_vy < 0) begin m_y = 0; m_vy = 0; m_mode = M_DN; end
            else begin
              m_y = m_y - m_vy;
              m_vy = (m_vy > 0) ? m_vy - 1 : 0;
              if (m_vy == 0) m_mode = M_DN;
            end
          end
          default: begin
            if (on_platform) begin m_mode = M_GND; m_vy = 0; end
            else begin
              m_y = (m_y + m_vy > YMAX) ? YMAX : m_y + m_vy;
              m_vy = (m_vy + 1 > MF) ? MF : m_vy + 1;
              if (m_y == YMAX) begin m_mode = M_GND; m_vy = 0; m_fell = 1; end
            end
          end
        endcase
        m_air = (m_mode != M_GND) ? 1 : 0;
      end else begin
        m_req = (m_req != 0 || rise != 0) ? 1 : 0;
      end
    end
    push_model();
  endtask

  task automatic step(input logic t, input logic l, input logic r, input logic j, input logic p);
    @(negedge clk);
    reset = want_rst;
    tick = t; left_press = l; right_press = r; jump_press = j; on_platform = p;
    model_edge();
  endtask

  // One tick followed by three idle cycles; snapshot taken the cycle after the tick.
  task automatic do_tick(input logic l, input logic r, input logic j, input logic p);
    step(1'b1, l, r, j, p);
    step(1'b0, l, r, j, p);
    s_x = int'(x); s_y = int'(y); s_fx = int'(furthest_x);
    s_air = int'(airborne); s_fell = int'(fell);
    step(1'b0, l, r, j, p);
    step(1'b0, l, r, j, p);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_x", int'(x), e.x);
        chk("sb_y", int'(y), e.y);
        chk("sb_furthest_x", int'(furthest_x), e.fx);
        chk("sb_airborne", int'(airborne), e.air);
        chk("sb_fell", int'(fell), e.fell);
      end
    end
  end

  initial begin : driver
    int exp_rise[7];
    logic jl, ll, rl, pl, tl;
    exp_rise = '{400, 394, 389, 385, 382, 380, 379};
    model_reset();

    want_rst = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_x", int'(x), 20);
    chk("rst_y", int'(y), 400);
    chk("rst_fx", int'(furthest_x), 20);
    chk("rst_air", int'(airborne), 1);
    chk("rst_fell", int'(fell), 0);

    want_rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("land_y", s_y, 400);
    chk("land_x", s_x, 20);
    chk("land_air", s_air, 0);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      do_tick(1'b0, 1'b0, 1'b1, 1'b0);
      chk("jump_y", s_y, exp_rise[i]);
      chk("jump_air", s_air, 1);
    end
    do_tick(1'b0, 1'b0, 1'b1, 1'b1);
    chk("jump_land_y", s_y, 379);
    for (int i = 0; i < 20; i++) begin
      do_tick(1'b0, 1'b0, 1'b1, 1'b1);
      chk("hold_jump_air", s_air, 0);
    end
    chk("hold_jump_y", s_y, 379);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    do_tick(1'b0, 1'b0, 1'b1, 1'b0);
    do_tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("midrise_y", s_y, 373);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 reset = 1'b0;
    want_rst = 1'b0;
    #1;
    chk("async_rst_x", int'(x), 20);
    chk("async_rst_y", int'(y), 400);
    chk("async_rst_air", int'(airborne), 1);
    void'(sb.pop_back());
    model_reset();
    push_model();
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    want_rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      do_tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 0) chk("first_tick_y", s_y, 400);
    end
    chk("fall_y470", s_y, 470);
    do_tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("perch_air", s_air, 0);
    do_tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("walkoff_y", s_y, 470);
    chk("walkoff_air", s_air, 1);
    for (int i = 0; i < 4; i++) begin
      do_tick(1'b0, 1'b0, 1'b0, 1'b0);
      chk("floor_y", s_y, (i == 0) ? 471 : (i == 1) ? 473 : (i == 2) ? 476 : 479);
      chk("floor_fell", s_fell, (i == 3) ? 1 : 0);
    end
    chk("fell_pulse_over", int'(fell), 0);
    chk("floor_air", int'(airborne), 0);

    for (int i = 0; i < 13; i++) do_tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("left_x7", s_x, 7);
    for (int i = 0; i < 3; i++) begin
      do_tick(1'b1, 1'b0, 1'b0, 1'b1);
      chk("left_sat_x", s_x, 6);
    end
    do_tick(1'b1, 1'b1, 1'b0, 1'b1);
    chk("both_x", s_x, 6);
    chk("furthest_hold", s_fx, 20);
    for (int i = 0; i < 634; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    do_tick(1'b0, 1'b1, 1'b0, 1'b1);
    chk("right_sat_x", s_x, 637);
    chk("right_fx", s_fx, 637);
    do_tick(1'b1, 1'b0, 1'b0, 1'b1);
    chk("back_x", s_x, 636);
    chk("back_fx", s_fx, 637);

    jl = 1'b0; ll = 1'b0; rl = 1'b0; pl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 6) == 0) jl = ~jl;
      if ($urandom_range(0, 9) == 0) ll = ~ll;
      if ($urandom_range(0, 9) == 0) rl = ~rl;
      if ($urandom_range(0, 4) == 0) pl = ($urandom_range(0, 9) < 4);
      tl = ($urandom_range(0, 2) == 0);
      want_rst = ($urandom_range(0, 299) != 0);
      step(tl, ll, rl, jl, pl);
    end
    want_rst = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
